// File: rtl/vram_wr_arbiter.sv
// Multi-channel VRAM write arbiter: per-channel FIFOs, round-robin or fixed-priority
// grant, region decode to one-hot write enables. Optional VRAM_WR_ERR_EN builds unmapped-write capture.
module vram_wr_arbiter #(
    parameter int                NUM_CH   = 3,
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 13,
    parameter int                ARB_MODE = 0,
    parameter logic [ADDR_W-1:0] PAT_BASE = 13'h0800,
    parameter logic [ADDR_W-1:0] PAL_BASE = 13'h1800,
    parameter logic [ADDR_W-1:0] SPR_BASE = 13'h1A00,
    parameter logic [ADDR_W-1:0] SPR_END  = 13'h1FFF
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_CH-1:0]                             ch_valid,
    output logic [NUM_CH-1:0]                             ch_ready,
    input  logic [NUM_CH*ADDR_W-1:0]                      ch_wraddr,
    input  logic [NUM_CH*64-1:0]                          ch_wrdata,
    input  logic [NUM_CH*8-1:0]                           ch_byteena,
    input  logic                                          vram_lock,
    output logic [3:0]                                    out_wren,
    output logic [ADDR_W-1:0]                             out_wraddr,
    output logic [63:0]                                   out_wrdata,
    output logic [7:0]                                    out_byteena,
    output logic                                          busy,
    output logic                                          err,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] err_ch
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + 64 + 8;

    logic [ENT_W-1:0]  mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [PTR_W:0]    count  [NUM_CH];

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] nonempty;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   cand;
    logic              grant_vld;

    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] head_addr;
    logic [63:0]       head_data;
    logic [7:0]        head_be;
    logic [ADDR_W-1:0] region_base;
    logic [3:0]        region_hit;

    // ready comes from the pre-pop count, so a full FIFO stays not-ready even while popping
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            nonempty[i] = (count[i] != '0);
            ch_ready[i] = (count[i] != (PTR_W+1)'(DEPTH));
            push[i]     = ch_valid[i] && ch_ready[i];
            pop[i]      = grant_vld && (grant_idx == CH_W'(i));
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!vram_lock) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (ARB_MODE == 1)
                    cand = CH_W'(k);
                else
                    cand = CH_W'((32'(rr_ptr) + k) % 32'(NUM_CH));
                if (!grant_vld && nonempty[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        head                              = mem[grant_idx][rd_ptr[grant_idx]];
        {head_addr, head_data, head_be}   = head;
        region_hit                        = '0;
        region_base                       = '0;
        if (head_addr < PAT_BASE) begin
            region_hit = 4'b0001;
        end else if (head_addr < PAL_BASE) begin
            region_hit  = 4'b0010;
            region_base = PAT_BASE;
        end else if (head_addr < SPR_BASE) begin
            region_hit  = 4'b0100;
            region_base = PAL_BASE;
        end else if (head_addr <= SPR_END) begin
            region_hit  = 4'b1000;
            region_base = SPR_BASE;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (push[i])
                mem[i][wr_ptr[i]] <= {ch_wraddr[i*ADDR_W +: ADDR_W],
                                      ch_wrdata[i*64 +: 64],
                                      ch_byteena[i*8 +: 8]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])
                    count[i] <= count[i] + 1'b1;
                else if (!push[i] && pop[i])
                    count[i] <= count[i] - 1'b1;
            end
        end
    end

    // Unmapped heads have no region bit set, so they pop with out_wren = 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_wren    <= '0;
            out_wraddr  <= '0;
            out_wrdata  <= '0;
            out_byteena <= '0;
            rr_ptr      <= '0;
        end else begin
            out_wren <= '0;
            if (grant_vld) begin
                out_wren    <= (head_be != '0) ? region_hit : '0;
                out_wraddr  <= head_addr - region_base;
                out_wrdata  <= head_data;
                out_byteena <= head_be;
                if (ARB_MODE == 0)
                    rr_ptr <= (32'(grant_idx) + 32'd1 >= 32'(NUM_CH)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign busy = (|nonempty) || (|out_wren);

`ifdef VRAM_WR_ERR_EN
    logic unmapped;
    assign unmapped = (region_hit == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err    <= 1'b0;
            err_ch <= '0;
        end else if (grant_vld && unmapped && !err) begin
            err    <= 1'b1;
            err_ch <= grant_idx;
        end
    end
`else
    assign err    = 1'b0;
    assign err_ch = '0;
`endif

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Bench for vram_wr_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are checked each cycle against a queue-based reference model plus directed literals.
module tb_vram_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   ch_valid;
    logic [38:0]  ch_wraddr;
    logic [191:0] ch_wrdata;
    logic [23:0]  ch_byteena;
    logic         vram_lock;

    logic [2:0]   o_ready [2];
    logic [3:0]   o_wren  [2];
    logic [12:0]  o_addr  [2];
    logic [63:0]  o_data  [2];
    logic [7:0]   o_be    [2];
    logic         o_busy  [2];
    logic         o_err   [2];
    logic [1:0]   o_errch [2];

    int total = 0;
    int bad   = 0;

`ifdef VRAM_WR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    vram_wr_arbiter #(.NUM_CH(3), .DEPTH(4), .ADDR_W(13), .ARB_MODE(0),
                      .SPR_END(13'h1FFF)) dut_rr (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_ready(o_ready[0]),
        .ch_wraddr(ch_wraddr), .ch_wrdata(ch_wrdata), .ch_byteena(ch_byteena),
        .vram_lock(vram_lock), .out_wren(o_wren[0]), .out_wraddr(o_addr[0]),
        .out_wrdata(o_data[0]), .out_byteena(o_be[0]), .busy(o_busy[0]),
        .err(o_err[0]), .err_ch(o_errch[0]));

    vram_wr_arbiter #(.NUM_CH(3), .DEPTH(4), .ADDR_W(13), .ARB_MODE(1),
                      .SPR_END(13'h1A3F)) dut_fp (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_ready(o_ready[1]),
        .ch_wraddr(ch_wraddr), .ch_wrdata(ch_wrdata), .ch_byteena(ch_byteena),
        .vram_lock(vram_lock), .out_wren(o_wren[1]), .out_wraddr(o_addr[1]),
        .out_wrdata(o_data[1]), .out_byteena(o_be[1]), .busy(o_busy[1]),
        .err(o_err[1]), .err_ch(o_errch[1]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel per instance, entry = {addr, data, be}
    logic [84:0] mq [2][3][$];
    int          rr_m    [2];
    logic [3:0]  e_wren  [2];
    logic [12:0] e_addr  [2];
    logic [63:0] e_data  [2];
    logic [7:0]  e_be    [2];
    logic        e_err   [2];
    logic [1:0]  e_errch [2];

    task automatic model_step(input int m);
        int sz[3];
        int g, c, a, spr_end, rgn, base;
        logic [84:0] ent;
        spr_end = (m == 0) ? 'h1FFF : 'h1A3F;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) mq[m][i].delete();
            rr_m[m] = 0; e_wren[m] = 0; e_addr[m] = 0; e_data[m] = 0; e_be[m] = 0;
            e_err[m] = 0; e_errch[m] = 0;
            return;
        end
        for (int i = 0; i < 3; i++) sz[i] = mq[m][i].size();
        g = -1;
        if (!vram_lock) begin
            for (int k = 0; k < 3; k++) begin
                c = (m == 1) ? k : (rr_m[m] + k) % 3;
                if (g < 0 && sz[c] > 0) g = c;
            end
        end
        e_wren[m] = 0;
        if (g >= 0) begin
            ent = mq[m][g].pop_front();
            a = int'(ent[84:72]);
            if (a < 'h800)           begin rgn = 0; base = 0; end
            else if (a < 'h1800)     begin rgn = 1; base = 'h800; end
            else if (a < 'h1A00)     begin rgn = 2; base = 'h1800; end
            else if (a <= spr_end)   begin rgn = 3; base = 'h1A00; end
            else                     begin rgn = -1; base = 0; end
            if (rgn < 0) begin
                if (!e_err[m]) begin e_err[m] = 1; e_errch[m] = 2'(g); end
            end else if (ent[7:0] != 0) begin
                e_wren[m] = 4'(1 << rgn);
                e_addr[m] = 13'(a - base);
                e_data[m] = ent[71:8];
                e_be[m]   = ent[7:0];
            end
            if (m == 0) rr_m[m] = (g + 1) % 3;
        end
        for (int i = 0; i < 3; i++)
            if (ch_valid[i] && sz[i] < 4)
                mq[m][i].push_back({ch_wraddr[i*13 +: 13], ch_wrdata[i*64 +: 64], ch_byteena[i*8 +: 8]});
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        for (int m = 0; m < 2; m++) begin
            logic [2:0] rdy;
            logic       bsy;
            bsy = (e_wren[m] != 0);
            for (int i = 0; i < 3; i++) begin
                rdy[i] = (mq[m][i].size() < 4);
                if (mq[m][i].size() > 0) bsy = 1;
            end
            check($sformatf("m%0d_wren", m), o_wren[m], e_wren[m]);
            check($sformatf("m%0d_ready", m), o_ready[m], rdy);
            check($sformatf("m%0d_busy", m), o_busy[m], bsy);
            check($sformatf("m%0d_err", m), o_err[m], ERR_EN ? e_err[m] : 1'b0);
            check($sformatf("m%0d_errch", m), o_errch[m], ERR_EN ? e_errch[m] : 2'd0);
            if (e_wren[m] != 0) begin
                check($sformatf("m%0d_addr", m), o_addr[m], e_addr[m]);
                check($sformatf("m%0d_data", m), o_data[m], e_data[m]);
                check($sformatf("m%0d_be", m), o_be[m], e_be[m]);
            end
        end
    end

    task automatic set_ch(input int c, input logic [12:0] a, input logic [63:0] d, input logic [7:0] be);
        ch_wraddr[c*13 +: 13] = a;
        ch_wrdata[c*64 +: 64] = d;
        ch_byteena[c*8 +: 8]  = be;
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push1(input int c, input logic [12:0] a, input logic [63:0] d, input logic [7:0] be);
        set_ch(c, a, d, be);
        ch_valid = 3'(1 << c);
        @(negedge clk);
        ch_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ch_valid = '0;
        vram_lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic region_case(input logic [12:0] a, input logic [3:0] ew, input logic [12:0] ea);
        push1(0, a, 64'h1111_2222_3333_0000 | 64'(a), 8'h3C);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rgn_wren_%h_m%0d", a, m), o_wren[m], ew);
            check($sformatf("rgn_addr_%h_m%0d", a, m), o_addr[m], ea);
        end
    endtask

    initial begin
        rst_n = 1'b0; vram_lock = 1'b0; ch_valid = '0;
        ch_wraddr = '0; ch_wrdata = '0; ch_byteena = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        check("rst_wren", o_wren[0], 4'b0000);
        check("rst_addr", o_addr[0], 13'h0000);
        check("rst_data", o_data[0], 64'h0);
        check("rst_be", o_be[0], 8'h00);
        check("rst_ready", o_ready[0], 3'b111);
        check("rst_busy", o_busy[0], 1'b0);
        check("rst_err", o_err[0], 1'b0);

        // single write, two-cycle latency
        push1(0, 13'h0805, 64'hDEADBEEF_01234567, 8'hFF);
        @(negedge clk);
        check("single_wren", o_wren[0], 4'b0010);
        check("single_addr", o_addr[0], 13'h0005);
        check("single_data", o_data[0], 64'hDEADBEEF_01234567);
        check("single_be", o_be[0], 8'hFF);

        // region boundaries
        region_case(13'h07FF, 4'b0001, 13'h07FF);
        region_case(13'h17FF, 4'b0010, 13'h0FFF);
        region_case(13'h19FF, 4'b0100, 13'h01FF);
        region_case(13'h1A00, 4'b1000, 13'h0000);

        // unmapped on the SPR_END=0x1A3F instance
        push1(1, 13'h1A40, 64'h0A, 8'hFF);
        push1(2, 13'h1FFF, 64'h0B, 8'hFF);
        @(negedge clk);
        check("unm_wren_fp", o_wren[1], 4'b0000);
        check("unm_wren_rr", o_wren[0], 4'b1000);
        check("unm_err_fp", o_err[1], ERR_EN);
        check("unm_errch_fp", o_errch[1], ERR_EN ? 2'd1 : 2'd0);

        // round-robin fairness
        do_reset();
        vram_lock = 1'b1;
        ch_valid = 3'b111;
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 3; c++) set_ch(c, 13'(j), 64'(c), 8'hFF);
            @(negedge clk);
        end
        ch_valid = '0;
        check("rr_full_ready_rr", o_ready[0], 3'b000);
        check("rr_full_ready_fp", o_ready[1], 3'b000);
        vram_lock = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("rr_ch_%0d", k), o_data[0][7:0], 8'(k % 3));
            check($sformatf("rr_addr_%0d", k), o_addr[0], 13'(k / 3));
            check($sformatf("fp_ch_%0d", k), o_data[1][7:0], 8'(k / 4));
            check($sformatf("fp_addr_%0d", k), o_addr[1], 13'(k % 4));
            check($sformatf("rr_busy_%0d", k), o_busy[0], 1'b1);
        end
        @(negedge clk);
        check("rr_tail_wren", o_wren[0], 4'b0000);
        check("rr_tail_busy", o_busy[0], 1'b0);

        // fixed priority and backpressure
        do_reset();
        vram_lock = 1'b1;
        set_ch(0, 13'h0000, 64'h0, 8'hFF);
        set_ch(2, 13'h0001, 64'h2, 8'hFF);
        ch_valid = 3'b001;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("bp_ready0_%0d", j), o_ready[1][0], (j < 3) ? 1'b1 : 1'b0);
        end
        ch_valid = 3'b101;
        vram_lock = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check($sformatf("fp_only_ch0_%0d", j), o_data[1][7:0], 8'h00);
            check($sformatf("fp_wren_%0d", j), o_wren[1], 4'b0001);
        end
        ch_valid = '0;
        repeat (12) @(negedge clk);

        // reset mid-stream with all FIFOs full
        vram_lock = 1'b1;
        ch_valid = 3'b111;
        for (int c = 0; c < 3; c++) set_ch(c, 13'h0100, 64'hBAD0_0000_0000_0000 | 64'(c), 8'hFF);
        repeat (5) @(negedge clk);
        do_reset();
        check("mid_rst_wren", o_wren[0], 4'b0000);
        check("mid_rst_busy", o_busy[0], 1'b0);
        check("mid_rst_ready", o_ready[0], 3'b111);
        check("mid_rst_ready_fp", o_ready[1], 3'b111);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("mid_rst_quiet_%0d", j), o_wren[0] | o_wren[1], 4'b0000);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            vram_lock = ($urandom_range(0, 4) == 0);
            ch_valid = 3'($urandom);
            for (int c = 0; c < 3; c++)
                set_ch(c, 13'($urandom), {$urandom, $urandom},
                       ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
            @(negedge clk);
        end
        rst_n = 1'b1;
        vram_lock = 1'b0;
        ch_valid = '0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
